// File: rtl/btn_pkg.sv
// btn_pkg: shared types and defaults for the push-button conditioner.
//   btn_state_t        per-channel debounce/repeat FSM state
//   DEF_*              default timing parameters in clk cycles (100 MHz)
//   BTN_*              channel index of each board button
//   max3               largest of three values, used to size the counter
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        REPEAT,
        RELEASE_WAIT
    } btn_state_t;

    localparam int DEF_DB_CYCLES     = 2_500_000;
    localparam int DEF_REPEAT_DELAY  = 50_000_000;
    localparam int DEF_REPEAT_PERIOD = 10_000_000;

    localparam int BTN_UP     = 0;
    localparam int BTN_DOWN   = 1;
    localparam int BTN_LEFT   = 2;
    localparam int BTN_RIGHT  = 3;
    localparam int BTN_CENTRE = 4;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debouncer and auto-repeat timer for one button.
//   clk, rst   system clock, asynchronous active-high reset
//   raw        raw bouncing button input (asynchronous)
//   db         debounced level
//   scen       one-cycle pulse on each debounced press
//   mcen       pulse on press, then auto-repeat pulses while held
//   rel        one-cycle pulse on each debounced release
module button_channel
    import btn_pkg::*;
#(
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic scen,
    output logic mcen,
    output logic rel
);

    localparam int CNT_W = $clog2(max3(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (DB_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("button_channel: timing parameters must be >= 2");
    end

    logic [1:0]       sync;
    logic             raw_s;
    logic [CNT_W-1:0] cnt;
    btn_state_t       state;

    assign raw_s = sync[1];

    // One counter serves every state: it is cleared on each transition and
    // compared against the limit of the state it is timing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync  <= '0;
            cnt   <= '0;
            state <= IDLE;
            db    <= 1'b0;
            scen  <= 1'b0;
            mcen  <= 1'b0;
            rel   <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            scen <= 1'b0;
            mcen <= 1'b0;
            rel  <= 1'b0;
            case (state)
                IDLE: begin
                    if (raw_s) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!raw_s) begin
                        state <= IDLE;
                    end else if (cnt == DB_LAST) begin
                        state <= HELD;
                        cnt   <= '0;
                        db    <= 1'b1;
                        scen  <= 1'b1;
                        mcen  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    if (!raw_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (cnt == RD_LAST) begin
                        state <= REPEAT;
                        cnt   <= '0;
                        mcen  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                REPEAT: begin
                    if (!raw_s) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (cnt == RP_LAST) begin
                        cnt  <= '0;
                        mcen <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back high resumes the hold with fresh repeat timing.
                    if (raw_s) begin
                        state <= HELD;
                        cnt   <= '0;
                    end else if (cnt == DB_LAST) begin
                        state <= IDLE;
                        cnt   <= '0;
                        db    <= 1'b0;
                        rel   <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: multi-channel push-button synchroniser/debouncer/repeater.
//   clk, rst   100 MHz system clock, asynchronous active-high reset
//   btn_raw    raw bouncing buttons (bit 0 up, 1 down, 2 left, 3 right, 4 centre)
//   btn_db     debounced levels
//   btn_scen   one-cycle press pulses
//   btn_mcen   press pulses plus auto-repeat pulses while held
//   btn_rel    one-cycle release pulses
module button_conditioner
    import btn_pkg::*;
#(
    parameter int N_BTN         = 5,
    parameter int DB_CYCLES     = DEF_DB_CYCLES,
    parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
    parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_db,
    output logic [N_BTN-1:0] btn_scen,
    output logic [N_BTN-1:0] btn_mcen,
    output logic [N_BTN-1:0] btn_rel
);

    if (N_BTN < 1) begin : g_bad_n
        $error("button_conditioner: N_BTN must be >= 1");
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        button_channel #(
            .DB_CYCLES    (DB_CYCLES),
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
        ) u_ch (
            .clk (clk),
            .rst (rst),
            .raw (btn_raw[i]),
            .db  (btn_db[i]),
            .scen(btn_scen[i]),
            .mcen(btn_mcen[i]),
            .rel (btn_rel[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: self-checking bench for button_conditioner.
module tb_button_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int RD = 20;
    localparam int RP = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_raw = '0;
    logic [N-1:0] btn_db, btn_scen, btn_mcen, btn_rel;

    int checks   = 0;
    int failures = 0;

    button_conditioner #(
        .N_BTN        (N),
        .DB_CYCLES    (DB),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .btn_db  (btn_db),
        .btn_scen(btn_scen),
        .btn_mcen(btn_mcen),
        .btn_rel (btn_rel)
    );

    always #5 clk = ~clk;

    // Reference model: the debounced level flips once DB+1 consecutive
    // synchronised samples disagree with it; repeat pulses are timed as an
    // age since the last press or the last bounce back into the hold.
    logic [N-1:0] p1, p2, m_db, m_scen, m_mcen, m_rel;
    int run[N];
    int age[N];

    task automatic model_reset();
        p1 = '0; p2 = '0; m_db = '0; m_scen = '0; m_mcen = '0; m_rel = '0;
        for (int i = 0; i < N; i++) begin
            run[i] = 0;
            age[i] = 0;
        end
    endtask

    task automatic model_step();
        logic s;
        for (int i = 0; i < N; i++) begin
            s = p2[i];
            m_scen[i] = 1'b0; m_mcen[i] = 1'b0; m_rel[i] = 1'b0;
            if (!m_db[i]) begin
                if (s) begin
                    run[i]++;
                    if (run[i] == DB + 1) begin
                        m_db[i] = 1'b1; run[i] = 0; age[i] = 0;
                        m_scen[i] = 1'b1; m_mcen[i] = 1'b1;
                    end
                end else run[i] = 0;
            end else if (!s) begin
                run[i]++;
                if (run[i] == DB + 1) begin
                    m_db[i] = 1'b0; run[i] = 0; m_rel[i] = 1'b1;
                end
            end else if (run[i] > 0) begin
                run[i] = 0; age[i] = 0;
            end else begin
                age[i]++;
                if (age[i] == RD || (age[i] > RD && (age[i] - RD) % RP == 0)) m_mcen[i] = 1'b1;
            end
        end
        p2 = p1;
        p1 = btn_raw;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset(); else model_step();
        @(negedge clk);
        check("model_db",   btn_db,   m_db);
        check("model_scen", btn_scen, m_scen);
        check("model_mcen", btn_mcen, m_mcen);
        check("model_rel",  btn_rel,  m_rel);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // sel: 0 scen, 1 rel, 2 mcen. n = ticks taken, -1 if the bound expired.
    task automatic ticks_until(input int sel, input int idx, input int lim, output int n);
        logic hit;
        n = -1;
        for (int k = 1; k <= lim; k++) begin
            tick();
            hit = (sel == 0) ? btn_scen[idx] : (sel == 1) ? btn_rel[idx] : btn_mcen[idx];
            if (hit) begin
                n = k;
                break;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] raw;
        int           n;
        logic [N-1:0] db, scen, mcen, rel;
    } vec_t;

    vec_t tbl[10];
    int   n, sp, scount;
    int   mq[$];
    int   exp_off[7] = '{0, 20, 28, 36, 44, 52, 60};
    int   hold[N];
    logic seen;

    initial begin
        tbl[0] = '{5'b00001, 6,  5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[1] = '{5'b00001, 1,  5'b00001, 5'b00001, 5'b00001, 5'b00000};
        tbl[2] = '{5'b00001, 1,  5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[3] = '{5'b00001, 18, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[4] = '{5'b00001, 1,  5'b00001, 5'b00000, 5'b00001, 5'b00000};
        tbl[5] = '{5'b00000, 6,  5'b00001, 5'b00000, 5'b00000, 5'b00000};
        tbl[6] = '{5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 5'b00001};
        tbl[7] = '{5'b00000, 1,  5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[8] = '{5'b00010, 3,  5'b00000, 5'b00000, 5'b00000, 5'b00000};
        tbl[9] = '{5'b00000, 8,  5'b00000, 5'b00000, 5'b00000, 5'b00000};

        model_reset();
        ticks(3);
        check("reset_all", btn_db | btn_scen | btn_mcen | btn_rel, '0);
        rst = 1'b0;

        // Clean press, repeat, release and bounce reject on a directed table.
        for (int v = 0; v < 10; v++) begin
            btn_raw = tbl[v].raw;
            ticks(tbl[v].n);
            check($sformatf("tbl%0d_db", v),   btn_db,   tbl[v].db);
            check($sformatf("tbl%0d_scen", v), btn_scen, tbl[v].scen);
            check($sformatf("tbl%0d_mcen", v), btn_mcen, tbl[v].mcen);
            check($sformatf("tbl%0d_rel", v),  btn_rel,  tbl[v].rel);
        end

        // Release with a one-cycle blip three cycles into the low period.
        btn_raw = 5'b00001;
        ticks_until(0, 0, 20, n);
        check_int("blip_press_latency", n, 7);
        ticks(5);
        seen = 1'b0;
        btn_raw = 5'b00000;
        for (int k = 0; k < 3; k++) begin tick(); seen |= btn_scen[0] | btn_rel[0]; end
        btn_raw = 5'b00001;
        tick(); seen |= btn_scen[0] | btn_rel[0];
        btn_raw = 5'b00000;
        for (int k = 0; k < 3; k++) begin tick(); seen |= btn_scen[0] | btn_rel[0]; end
        check_int("blip_no_pulse", int'(seen), 0);
        check_int("blip_db_held", int'(btn_db[0]), 1);
        ticks_until(1, 0, 20, n);
        check_int("blip_release_latency", n, 4);
        ticks(3);

        // Auto-repeat on bit 2 held for 70 cycles.
        btn_raw = 5'b00100;
        sp = -1; scount = 0;
        for (int k = 0; k < 70; k++) begin
            tick();
            if (btn_scen[2]) begin sp = k; scount++; end
            if (btn_mcen[2]) mq.push_back(k);
        end
        check_int("rep_scen_count", scount, 1);
        check_int("rep_press_tick", sp, 6);
        check_int("rep_mcen_count", mq.size(), 7);
        for (int j = 0; j < 7 && j < mq.size(); j++)
            check_int($sformatf("rep_offset%0d", j), mq[j] - sp, exp_off[j]);
        btn_raw = 5'b00000;
        ticks(10);

        // Simultaneous channels 0 and 3.
        btn_raw = 5'b01001;
        ticks_until(0, 0, 20, n);
        check_int("sim_press_latency", n, 7);
        check("sim_scen_pair", btn_scen, 5'b01001);
        check("sim_db_pair", btn_db, 5'b01001);
        ticks(5);
        btn_raw = 5'b00000;
        ticks_until(1, 0, 20, n);
        check_int("sim_release_latency", n, 7);
        check("sim_rel_pair", btn_rel, 5'b01001);
        ticks(4);

        // Asynchronous reset while bit 4 is auto-repeating.
        btn_raw = 5'b10000;
        ticks(40);
        check("pre_reset_db", btn_db, 5'b10000);
        #1 rst = 1'b1;
        #1 check("async_reset_out", btn_db | btn_scen | btn_mcen | btn_rel, '0);
        ticks(3);
        rst = 1'b0;
        ticks_until(0, 4, 20, n);
        check_int("post_reset_press", n, 7);

        // Randomised bouncing on all channels against the model.
        for (int i = 0; i < N; i++) hold[i] = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                hold[i]--;
                if (hold[i] <= 0) begin
                    btn_raw[i] = ~btn_raw[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                           : int'($urandom_range(1, 7));
                end
            end
            tick();
        end
        btn_raw = '0;
        ticks(20);
        check("final_idle", btn_db, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Multi-channel push-button conditioner upstream of `block_controller`. Synchronises raw board buttons (up, down, left, right, centre), debounces each, and produces clean levels plus single-cycle press, auto-repeat and release pulses. `btn_db` drives the `up/down/left/right` level inputs. `btn_scen` and `btn_mcen` drive one-shot actions such as fire and held-button stepping. All outputs are synchronous to `clk`, the 100 MHz system clock.

## Interface
- `N_BTN`, 5: number of independent channels. Bit 0 = up, 1 = down, 2 = left, 3 = right, 4 = centre.
- `DB_CYCLES`, 2_500_000: debounce window in clk cycles (25 ms). Must be ≥2.
- `REPEAT_DELAY`, 50_000_000: cycles from press pulse to first auto-repeat pulse (0.5 s). Must be ≥2.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent auto-repeat pulses (0.1 s). Must be ≥2.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `btn_raw`, in, N_BTN: raw, asynchronous, bouncing button inputs.
- `btn_db`, out, N_BTN: debounced level.
- `btn_scen`, out, N_BTN: single-cycle pulse on each debounced press.
- `btn_mcen`, out, N_BTN: pulse on press, then periodic auto-repeat pulses while held.
- `btn_rel`, out, N_BTN: single-cycle pulse on each debounced release.

## Operation
- Per channel: a 2-FF synchroniser (`raw_s`), one counter of width `CNT_W = $clog2(max(DB_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))`, and a 5-state FSM. Channels are fully independent.
- All outputs are registered. Reset drives all outputs, synchroniser flops and counters to 0 and all FSMs to IDLE.
- IDLE (db=0): if `raw_s`=1, go to PRESS_WAIT with cnt=0.
- PRESS_WAIT (db=0):
  - `raw_s`=0: go to IDLE.
  - `raw_s`=1 and cnt==DB_CYCLES-1: go to HELD with cnt=0; db←1; scen and mcen pulse for one cycle.
  - Otherwise cnt++.
- HELD (db=1):
  - `raw_s`=0: go to RELEASE_WAIT with cnt=0.
  - cnt==REPEAT_DELAY-1: go to REPEAT with cnt=0; mcen pulses.
  - Otherwise cnt++.
- REPEAT (db=1):
  - `raw_s`=0: go to RELEASE_WAIT with cnt=0.
  - cnt==REPEAT_PERIOD-1: cnt=0; mcen pulses.
  - Otherwise cnt++.
- RELEASE_WAIT (db=1, no mcen):
  - `raw_s`=1: go to HELD with cnt=0. Repeat timing restarts; no scen.
  - `raw_s`=0 and cnt==DB_CYCLES-1: go to IDLE; db←0; rel pulses.
  - Otherwise cnt++.
- A glitch shorter than DB_CYCLES+1 consecutive synchronised samples never changes `btn_db` and never pulses any output.
- Counters never exceed their compare value, so there is no wrap.
- Pulse outputs default to 0 every cycle unless a transition above asserts them.

## Timing
- Press latency: with `btn_raw[i]` high and stable from edge E0, `btn_db[i]`, `btn_scen[i]` and `btn_mcen[i]` assert after edge E0+DB_CYCLES+2. This is 2 synchroniser edges plus DB_CYCLES+1 FSM samples.
- `btn_scen` and `btn_rel` are high for exactly one cycle per event.
- Auto-repeat: press pulse at edge P gives mcen pulses at P+REPEAT_DELAY, then P+REPEAT_DELAY+k·REPEAT_PERIOD for k≥1.
- Release latency: with `btn_raw[i]` low and stable from edge R0, `btn_db[i]` deasserts and `btn_rel[i]` pulses after edge R0+DB_CYCLES+2.
- scen, mcen and rel of one channel are never high in the same cycle as that channel's rel and scen respectively.
- Reset mid-operation: outputs go to 0 asynchronously.
  - After deassertion with the button still held, the channel behaves as a fresh press. A new scen follows DB_CYCLES+2 edges after the first post-reset edge.
- Simultaneous presses on several channels produce identical, independent timing per channel.

## Structure
- Package `btn_pkg`:
  - FSM state typedef: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT, 3-bit encoding.
  - Default constants for the three timing parameters.
  - Channel index constants BTN_UP, BTN_DOWN, BTN_LEFT, BTN_RIGHT, BTN_CENTRE.
- Sub-module `button_channel`: synchroniser, counter and FSM for one button, with the same timing parameters and 1-bit ports.
- `button_conditioner` instantiates N_BTN copies in a generate loop.
- Elaboration-time checks reject parameter values <2.

## Test plan
All scenarios use DB_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, N_BTN=5.
- Clean press: `btn_raw[0]` rises before E0 and is held. `btn_db[0]`, `btn_scen[0]` and `btn_mcen[0]` assert after E6. scen is low again after E7. Other bits stay 0.
- Bounce reject: `btn_raw[1]` high for 3 cycles, then low. No output bit 1 ever asserts; the FSM returns to IDLE.
- Auto-repeat: hold `btn_raw[2]` for 70 cycles. mcen[2] pulses at press edge P, P+20, P+28, P+36, P+44, P+52 …, each one cycle wide. scen[2] pulses only at P.
- Release and release-bounce:
  - Drop `btn_raw[0]` at R0 and hold low: db[0]=0 and rel[0] pulses after R0+6.
  - Repeat with a 1-cycle high blip 3 cycles into the low period: db[0] stays 1, no scen and no rel. The release is then measured from the last low edge.
- Simultaneous channels: bits 0 and 3 rise in the same cycle. Both assert db/scen on the same edge, and their rel pulses match on release.
- Reset mid-hold: assert `rst` while bit 4 is in REPEAT. All outputs go to 0 immediately. Deassert with the button still held: scen[4] pulses again 6 edges after the first post-reset edge.
